// File: rtl/acia_rx_pkg.sv
// acia_rx_pkg: shared definitions for the ACIA serial receiver.
//  - rx_state_e : receiver FSM state encoding (3 bits)
//  - calc_div   : bit-period divider from tick rate and baud rate
package acia_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // Ticks per bit; callers need the result to be at least 8 so that the
  // half-bit start delay and the 3-tap vote window fit inside one bit.
  function automatic int calc_div(input int tick_hz, input int baud);
    return tick_hz / baud;
  endfunction

endpackage

// File: rtl/acia_rx_sync.sv
// acia_rx_sync: brings the raw serial line into the clk domain and cleans it.
//  clk, reset : system clock, async active-high reset
//  pclk       : tick enable; the vote window only advances on ticks
//  rx_serial  : raw line, idle high, asynchronous
//  filtered   : 2-of-3 majority of the last three ticked samples
module acia_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic pclk,
  input  logic rx_serial,
  output logic filtered
);

  logic [1:0] sync;
  logic [2:0] win;

  // Synchronizer runs every clk; the window only on ticks, so a one-clk
  // glitch can land in at most one tap and is outvoted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= 2'b11;
      win  <= 3'b111;
    end else begin
      sync <= {sync[0], rx_serial};
      if (pclk) win <= {win[1:0], sync[1]};
    end
  end

  assign filtered = (win[0] & win[1]) | (win[0] & win[2]) | (win[1] & win[2]);

endmodule

// File: rtl/acia_rx.sv
// acia_rx: 8N1 asynchronous receiver feeding the ACIA register block.
//  clk, reset : system clock, async active-high reset
//  pclk       : peripheral tick enable; all receiver state advances on ticks
//  rx_serial  : raw serial line, idle high
//  rx_dat     : last completed byte (LSB first on the line)
//  rx_stb     : one-tick strobe when a byte completes
//  rx_err     : framing error of the last completed frame (stop bit low)
module acia_rx
  import acia_rx_pkg::*;
#(
  parameter int clk_freq = 4000000,
  parameter int sym_rate = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pclk,
  input  logic       rx_serial,
  output logic [7:0] rx_dat,
  output logic       rx_stb,
  output logic       rx_err
);

  localparam int DIV  = calc_div(clk_freq, sym_rate);
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  logic            filtered;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      sr;
  rx_state_e       state;
  logic            samp;

  acia_rx_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .pclk      (pclk),
    .rx_serial (rx_serial),
    .filtered  (filtered)
  );

  // Only meaningful inside the pclk branch below.
  assign samp = (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sr      <= '0;
      rx_dat  <= 8'h00;
      rx_stb  <= 1'b0;
      rx_err  <= 1'b0;
    end else if (pclk) begin
      // Strobe lives for exactly one tick.
      rx_stb <= 1'b0;
      // Free-running bit timer; IDLE overrides it with the half-bit delay
      // so the first sample lands in the middle of the start bit.
      cnt <= samp ? CW'(DIV - 1) : cnt - 1'b1;
      case (state)
        ST_IDLE: begin
          if (!filtered) begin
            state <= ST_START;
            cnt   <= CW'(HALF - 1);
          end
        end
        ST_START: begin
          if (samp) begin
            if (!filtered) begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end else begin
              state <= ST_IDLE;   // too short to be a start bit
            end
          end
        end
        ST_DATA: begin
          if (samp) begin
            sr      <= {filtered, sr[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (samp) begin
            rx_dat <= sr;
            rx_stb <= 1'b1;
            rx_err <= ~filtered;
            // Low stop bit: park until the line goes high so a held-low
            // line never yields phantom frames.
            state  <= filtered ? ST_IDLE : ST_BREAK;
          end
        end
        ST_BREAK: begin
          if (filtered) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acia_rx.sv
// tb_acia_rx: self-checking bench for acia_rx. Bytes are serialised at the
// line level; a monitor records every strobe (data, error, cycle, width)
// and each scenario compares what it captured against what it sent.
module tb_acia_rx;

  localparam int DIV = 416;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pclk = 1'b1;
  logic       rx_serial = 1'b1;
  logic [7:0] rx_dat;
  logic       rx_stb;
  logic       rx_err;

  int checks = 0;
  int errors = 0;

  int  cyc = 0;
  bit  pclk_div4 = 1'b0;
  int  bit_clks = DIV;

  logic [7:0] got_dat[$];
  logic       got_err[$];
  int         got_cyc[$];
  int         stb_w[$];
  int         cur_w = 0;
  logic       stb_q = 1'b0;

  logic [7:0] exp_dat[$];
  logic       exp_err[$];

  acia_rx #(.clk_freq(4000000), .sym_rate(9600)) dut (
    .clk       (clk),
    .reset     (reset),
    .pclk      (pclk),
    .rx_serial (rx_serial),
    .rx_dat    (rx_dat),
    .rx_stb    (rx_stb),
    .rx_err    (rx_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin : pclk_gen
    int ph = 0;
    forever begin
      @(negedge clk);
      if (pclk_div4) begin
        ph   = (ph + 1) % 4;
        pclk = (ph == 0);
      end else begin
        pclk = 1'b1;
      end
    end
  end

  // Strobe monitor: capture on the rising side, width on the falling side.
  always @(negedge clk) begin
    if (rx_stb) cur_w++;
    else if (cur_w != 0) begin
      stb_w.push_back(cur_w);
      cur_w = 0;
    end
    if (rx_stb && !stb_q) begin
      got_dat.push_back(rx_dat);
      got_err.push_back(rx_err);
      got_cyc.push_back(cyc);
    end
    stb_q = rx_stb;
  end

  task automatic clear_obs();
    got_dat.delete(); got_err.delete(); got_cyc.delete(); stb_w.delete();
    exp_dat.delete(); exp_err.delete();
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx_serial = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int len);
    drive_bit(1'b0, len);
    for (int i = 0; i < 8; i++) drive_bit(b[i], len);
    drive_bit(1'b1, len);
    exp_dat.push_back(b);
    exp_err.push_back(1'b0);
  endtask

  // Compare everything captured against the expected list.
  task automatic check_frames(input string tag);
    checks++;
    if (got_dat.size() !== exp_dat.size()) begin
      errors++;
      $display("FAIL %s count: got %0d strobes, want %0d", tag, got_dat.size(), exp_dat.size());
    end
    for (int i = 0; i < got_dat.size() && i < exp_dat.size(); i++) begin
      checks++;
      if (got_dat[i] !== exp_dat[i]) begin
        errors++;
        $display("FAIL %s dat[%0d]: got %02h want %02h", tag, i, got_dat[i], exp_dat[i]);
      end
      checks++;
      if (got_err[i] !== exp_err[i]) begin
        errors++;
        $display("FAIL %s err[%0d]: got %0b want %0b", tag, i, got_err[i], exp_err[i]);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rx_dat !== 8'h00 || rx_stb !== 1'b0 || rx_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got dat=%02h stb=%0b err=%0b want 00/0/0", rx_dat, rx_stb, rx_err);
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (rx_stb !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_stb: got %0b want 0", rx_stb);
    end
  endtask

  task automatic test_basic();
    int t0;
    clear_obs();
    t0 = cyc;
    send_byte(8'h55, DIV);
    drive_bit(1'b1, 2 * DIV);
    check_frames("basic");
    checks++;
    if (stb_w.size() != 1 || stb_w[0] != 1) begin
      errors++;
      $display("FAIL basic_stb_width: got %0d pulses (first %0d clk) want 1 pulse of 1 clk",
               stb_w.size(), (stb_w.size() > 0) ? stb_w[0] : -1);
    end
    // Stop-bit centre is 9.5 bit times after the start edge, plus a few
    // clocks of synchronizer and vote latency.
    checks++;
    if (got_cyc.size() < 1 || got_cyc[0] - t0 < (DIV * 19) / 2 - 4 ||
        got_cyc[0] - t0 > (DIV * 19) / 2 + 12) begin
      errors++;
      $display("FAIL basic_latency: got %0d clk want %0d +/-", (got_cyc.size() > 0) ? got_cyc[0] - t0 : -1,
               (DIV * 19) / 2);
    end
  endtask

  task automatic test_framing();
    logic [7:0] b;
    clear_obs();
    b = 8'hA3;
    drive_bit(1'b0, DIV);
    for (int i = 0; i < 8; i++) drive_bit(b[i], DIV);
    drive_bit(1'b0, 20 * DIV);          // stop bit low, line held in break
    exp_dat.push_back(8'hA3);
    exp_err.push_back(1'b1);
    drive_bit(1'b1, 2 * DIV);
    check_frames("framing_err");
    checks++;
    if (got_dat.size() != 1) begin
      errors++;
      $display("FAIL framing_no_second: got %0d strobes want 1", got_dat.size());
    end
    clear_obs();
    send_byte(8'h3C, DIV);
    drive_bit(1'b1, 2 * DIV);
    check_frames("framing_recover");
  endtask

  task automatic test_glitch();
    logic [7:0] d0;
    logic       e0;
    clear_obs();
    d0 = rx_dat;
    e0 = rx_err;
    drive_bit(1'b0, 100);
    drive_bit(1'b1, 2 * DIV);
    checks++;
    if (got_dat.size() != 0) begin
      errors++;
      $display("FAIL glitch_stb: got %0d strobes want 0", got_dat.size());
    end
    checks++;
    if (rx_dat !== d0 || rx_err !== e0) begin
      errors++;
      $display("FAIL glitch_hold: got dat=%02h err=%0b want %02h/%0b", rx_dat, rx_err, d0, e0);
    end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    send_byte(8'h00, DIV + DIV / 50);
    send_byte(8'hFF, DIV - DIV / 50);
    send_byte(8'h81, DIV + DIV / 50);
    drive_bit(1'b1, 2 * DIV);
    check_frames("back_to_back");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    clear_obs();
    b = 8'h7E;
    drive_bit(1'b0, DIV);
    for (int i = 0; i < 3; i++) drive_bit(b[i], DIV);
    #3 reset = 1'b1;
    #1;
    checks++;
    if (rx_dat !== 8'h00 || rx_stb !== 1'b0 || rx_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: got dat=%02h stb=%0b err=%0b want 00/0/0", rx_dat, rx_stb, rx_err);
    end
    @(negedge clk);
    rx_serial = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    drive_bit(1'b1, 2 * DIV);
    send_byte(8'h42, DIV);
    drive_bit(1'b1, 2 * DIV);
    check_frames("midreset_next");
  endtask

  task automatic test_pclk_div4();
    logic [7:0] b;
    int len;
    clear_obs();
    pclk_div4 = 1'b1;
    len = 4 * DIV;
    b = 8'hC9;
    drive_bit(1'b1, 64);
    drive_bit(1'b0, len);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        // One-clk inverted blip near the bit centre; the vote must drop it.
        rx_serial = b[i];
        repeat (len / 2) @(negedge clk);
        rx_serial = ~b[i];
        @(negedge clk);
        rx_serial = b[i];
        repeat (len - len / 2 - 1) @(negedge clk);
      end else begin
        drive_bit(b[i], len);
      end
    end
    drive_bit(1'b1, len);
    exp_dat.push_back(b);
    exp_err.push_back(1'b0);
    drive_bit(1'b1, len);
    check_frames("pclk_div4");
    checks++;
    if (stb_w.size() != 1 || stb_w[0] != 4) begin
      errors++;
      $display("FAIL pclk_div4_width: got %0d pulses (first %0d clk) want 1 pulse of 4 clk",
               stb_w.size(), (stb_w.size() > 0) ? stb_w[0] : -1);
    end
    pclk_div4 = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_random();
    clear_obs();
    for (int i = 0; i < 3; i++) begin
      logic [7:0] b;
      int len;
      b   = 8'($urandom_range(0, 255));
      len = DIV - 4 + int'($urandom_range(0, 8));
      send_byte(b, len);
      drive_bit(1'b1, int'($urandom_range(0, 200)));
    end
    drive_bit(1'b1, 2 * DIV);
    check_frames("random");
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_framing();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_pclk_div4();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
